// File: rtl/md_pkg.sv
// Shared types and constants for the RV64M iterative multiply/divide unit.
package md_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  function automatic logic [XLEN-1:0] sext32(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/md_unit_rv64_if.sv
// Request/response bundle between the multicycle control path and the MD unit.
interface md_unit_rv64_if;
  logic        start;
  logic [2:0]  funct3;
  logic        is_word;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  modport master (
    output start, funct3, is_word, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, is_word, op_a, op_b,
    output busy, done, result
  );
endinterface

// File: rtl/md_sign_fix.sv
// Final sign application, high/low half select and W-variant sign extension.
module md_sign_fix
  import md_pkg::*;
(
  input  logic [2*XLEN-1:0] val,
  input  logic              neg,
  input  logic              sel_hi,
  input  logic              word,
  output logic [XLEN-1:0]   res
);
  logic [2*XLEN-1:0] val_s;
  logic [XLEN-1:0]   half;

  // negate the full-width magnitude, pick a half, then narrow for W ops
  always_comb begin
    val_s = neg ? (~val + 1'b1) : val;
    half  = sel_hi ? val_s[2*XLEN-1:XLEN] : val_s[XLEN-1:0];
    res   = word ? sext32(half[WLEN-1:0]) : half;
  end
endmodule

// File: rtl/md_unit_rv64.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Optional macro MD_EARLY_OUT_EN: skip iteration for zero multiplies and for
// divides whose dividend magnitude is below the divisor magnitude.
module md_unit_rv64
  import md_pkg::*;
(
  input logic         CLK,
  input logic         RST,
  md_unit_rv64_if.slave bus
);
  md_state_t       state;
  md_op_t          op_q;
  logic            word_q, neg_main, neg_rem;
  logic [6:0]      cnt;
  logic [XLEN-1:0] hi, lo, dvs;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic            is_mul_in, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            div_zero, div_ovf, skip_early;

  // operand extension, magnitudes and special-case detection at acceptance
  always_comb begin
    is_mul_in = ~bus.funct3[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    if (is_mul_in) begin
      a_signed = bus.is_word || (bus.funct3 != 3'b011);
      b_signed = bus.is_word || (bus.funct3[1] == 1'b0);
    end else begin
      a_signed = ~bus.funct3[0];
      b_signed = ~bus.funct3[0];
    end
    a_ext = bus.is_word ? (a_signed ? sext32(bus.op_a[WLEN-1:0]) : {32'b0, bus.op_a[WLEN-1:0]})
                        : bus.op_a;
    b_ext = bus.is_word ? (b_signed ? sext32(bus.op_b[WLEN-1:0]) : {32'b0, bus.op_b[WLEN-1:0]})
                        : bus.op_b;
    a_neg = a_signed & a_ext[XLEN-1];
    b_neg = b_signed & b_ext[XLEN-1];
    a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;
    div_zero = ~is_mul_in & (b_ext == '0);
    div_ovf  = ~is_mul_in & a_signed & (b_ext == '1) &
               (a_ext == (bus.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
`ifdef MD_EARLY_OUT_EN
    skip_early = is_mul_in ? ((a_ext == '0) || (b_ext == '0)) : (a_mag < b_mag);
`else
    skip_early = 1'b0;
`endif
  end

  logic [XLEN:0]     sum_m, rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   rem_sub;
  logic              is_mul_q;
  logic [2*XLEN-1:0] fix_val;
  logic              fix_neg, fix_hi;
  logic [XLEN-1:0]   fix_res;

  // one iteration step and the FIX-stage operand selection
  always_comb begin
    sum_m    = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : 65'd0);
    rem_sh   = {hi, lo[XLEN-1]};
    div_ge   = rem_sh >= {1'b0, dvs};
    rem_sub  = rem_sh[XLEN-1:0] - dvs;
    is_mul_q = ~op_q[2];
    if (is_mul_q)
      fix_val = word_q ? {64'b0, hi[WLEN-1:0], lo[XLEN-1:WLEN]} : {hi, lo};
    else
      fix_val = op_q[1] ? {64'b0, hi} : {64'b0, lo};
    fix_neg = (!is_mul_q && op_q[1]) ? neg_rem : neg_main;
    fix_hi  = is_mul_q & ~word_q & (op_q != OP_MUL);
  end

  md_sign_fix u_sign_fix (
    .val    (fix_val),
    .neg    (fix_neg),
    .sel_hi (fix_hi),
    .word   (word_q),
    .res    (fix_res)
  );

  // control FSM and iteration registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      word_q   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q     <= md_op_t'(bus.funct3);
            word_q   <= bus.is_word;
            busy_q   <= 1'b1;
            dvs      <= is_mul_in ? a_mag : b_mag;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            cnt      <= bus.is_word ? 7'(WLEN) : 7'(XLEN);
            if (div_zero) begin
              hi       <= a_mag;
              lo       <= '1;
              neg_main <= 1'b0;
              state    <= FIX;
            end else if (div_ovf) begin
              hi       <= '0;
              lo       <= a_mag;
              neg_main <= 1'b0;
              neg_rem  <= 1'b0;
              state    <= FIX;
            end else if (skip_early) begin
              hi    <= is_mul_in ? '0 : a_mag;
              lo    <= '0;
              state <= FIX;
            end else begin
              hi    <= '0;
              lo    <= is_mul_in ? b_mag
                                 : (bus.is_word ? {a_mag[WLEN-1:0], 32'b0} : a_mag);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (is_mul_q) begin
            hi <= sum_m[XLEN:1];
            lo <= {sum_m[0], lo[XLEN-1:1]};
          end else begin
            hi <= div_ge ? rem_sub : rem_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_md_unit_rv64.sv
// Directed, table-driven bench for md_unit_rv64 plus reset-abort and held-start sequences.
module tb_md_unit_rv64;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  md_unit_rv64_if bus();

  md_unit_rv64 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef MD_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 66;
`endif

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // waits for IDLE, issues one start, returns result and cycles-to-done
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    @(posedge CLK); #1;
    bus.funct3 = f3; bus.is_word = w; bus.op_a = a; bus.op_b = b; bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    res = bus.result;
  endtask

  initial begin
    logic [63:0] res;
    int lat;
    int n_done;

    vecs[0]  = '{"MUL 7*-3",      3'b000, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[1]  = '{"MULHU -1*2",    3'b011, 1'b0, '1, 64'd2, 64'd1, 66};
    vecs[2]  = '{"MULH -1*2",     3'b001, 1'b0, '1, 64'd2, '1, 66};
    vecs[3]  = '{"MULHSU -1*2",   3'b010, 1'b0, '1, 64'd2, '1, 66};
    vecs[4]  = '{"DIV -7/2",      3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[5]  = '{"REM -7/2",      3'b110, 1'b0, -64'sd7, 64'd2, '1, 66};
    vecs[6]  = '{"DIVUW 2^31/1",  3'b101, 1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34};
    vecs[7]  = '{"DIVU 5/0",      3'b101, 1'b0, 64'd5, 64'd0, '1, 2};
    vecs[8]  = '{"REM 5/0",       3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 2};
    vecs[9]  = '{"DIV ovf",       3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2};
    vecs[10] = '{"REMW ovf",      3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 2};
    vecs[11] = '{"MULW",          3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34};
    vecs[12] = '{"REMU 100/7",    3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66};
    vecs[13] = '{"DIVW -100/7",   3'b100, 1'b1, 64'h0000_0000_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34};
    vecs[14] = '{"REMUW",         3'b111, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'hF, 34};
    vecs[15] = '{"DIVU 3/7",      3'b101, 1'b0, 64'd3, 64'd7, 64'd0, EO_LAT};

    bus.start = 1'b0; bus.funct3 = 3'b000; bus.is_word = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", {63'b0, bus.busy}, 64'd0);
    check("reset done", {63'b0, bus.done}, 64'd0);
    check("reset result", bus.result, 64'd0);
    RST = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, " result"}, res, vecs[i].exp);
      check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, " busy@done"}, {63'b0, bus.busy}, 64'd0);
    end

    // reset in the middle of a divide aborts it without a done pulse
    @(posedge CLK); #1;
    bus.funct3 = 3'b100; bus.is_word = 1'b0; bus.op_a = 64'd100; bus.op_b = 64'd7; bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    check("abort busy in calc", {63'b0, bus.busy}, 64'd1);
    repeat (9) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    check("abort busy after rst", {63'b0, bus.busy}, 64'd0);
    RST = 1'b0;
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge CLK); #1;
      if (bus.done) n_done++;
    end
    check("abort no done", 64'(n_done), 64'd0);
    run_op(3'b100, 1'b0, -64'sd7, 64'd2, res, lat);
    check("post-rst DIV", res, 64'hFFFF_FFFF_FFFF_FFFD);
    check("post-rst latency", 64'(lat), 64'd66);

    // start held high while operands change: only the accepted operands count
    @(posedge CLK); #1;
    bus.funct3 = 3'b000; bus.is_word = 1'b0; bus.op_a = 64'd3; bus.op_b = 64'd5; bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.op_a = 64'd9; bus.op_b = 64'd9;
    lat = 1;
    while (!bus.done && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    check("held MUL result", bus.result, 64'd15);
    check("held MUL latency", 64'(lat), 64'd66);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check("hold result stable", bus.result, 64'd15);
      check("start in DONE ignored", {63'b0, bus.busy}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/md_unit_rv64.md
Name: md_unit_rv64

Overview:
Iterative RV64M multiply/divide unit. It sits beside the 64-bit ALU in the multicycle datapath. Operands come from the A/B operand registers. The result goes to the ALU-result mux and then to the ALU output register. The control state machine starts an operation and stalls until the unit reports done. One bit per cycle: radix-2 shift-add multiply and restoring divide.

Parameters:
XLEN, 64, datapath width; the only supported value is 64.
WLEN, 32, operand width for the word (W) variants.

Ports:
CLK     in   1     clock
RST     in   1     synchronous active-high reset
start   in   1     1-cycle request; sampled only in IDLE
funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
is_word in   1     selects the W variant (MULW/DIVW/DIVUW/REMW/REMUW)
op_a    in   XLEN  rs1 value
op_b    in   XLEN  rs2 value
busy    out  1     high from the cycle after an accepted start until done
done    out  1     1-cycle pulse; result is valid in this cycle
result  out  XLEN  result; held stable from done until the next accepted start

Behaviour:
- Interface: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- Reset during an operation aborts it. No done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE + start: latch funct3 and is_word.
  - Take operand magnitudes: signed when funct3 selects a signed operand.
  - MULHSU: op_a is signed, op_b is unsigned.
  - W variants use op_a[31:0]/op_b[31:0], sign- or zero-extended per funct3.
  - Go to CALC with counter = N, where N = XLEN, or WLEN when is_word.
- CALC: one iteration per cycle; counter decrements; at 0 go to FIX.
  - MUL: 128-bit product register {hi, lo}. Add the multiplicand to hi when lo[0]=1, then shift right.
  - DIV: restoring step on {rem, quo}. Shift left 1; subtract the divisor; keep the difference if it is non-negative and set the quotient bit.
- FIX (1 cycle):
  - Apply the sign: product negated if the operand signs differ; quotient likewise; remainder takes the dividend's sign.
  - Select the output: MUL→low 64 bits; MULH*→high 64 bits; DIV*→quotient; REM*→remainder.
  - W variants: result = sign-extension of bit 31 of the 32-bit result (for DIVUW/REMUW too).
  - is_word with funct3 001..011 produces the MULW result.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Latency: start accepted at edge k; done is high in cycle k+N+2 (66 for 64-bit ops, 34 for W ops).
- Special cases: detected in IDLE; skip CALC and go to FIX, so done arrives at k+2.
  - Divide by zero: quotient = all ones (DIV/DIVU); remainder = dividend.
  - Signed overflow (most-negative / −1, at the respective width): quotient = dividend; remainder = 0.
- Back-to-back: start may be asserted in the DONE cycle. It is ignored; it is accepted only in IDLE, so it must be held or reissued in IDLE.
- start while busy is ignored. Operands are sampled only at acceptance; later changes on op_a/op_b have no effect.

Optional Feature:
MD_EARLY_OUT_EN:
- With the macro defined, multiplication with either operand zero skips CALC (result 0, done at k+2).
- With the macro defined, division with |dividend| < |divisor| also skips CALC (quotient 0, remainder = dividend, done at k+2).
- Without the macro, all non-special operations take the full N+2 latency.

Decomposition:
- Package md_pkg holds:
  - md_state_t enum (IDLE/CALC/FIX/DONE).
  - md_op_t funct3 encoding enum.
  - XLEN/WLEN constants.
  - Helper function sext32.
- One sub-module, md_sign_fix: combinational negation and W sign-extension used in FIX. The FSM and iteration datapath stay in md_unit_rv64.

Test Plan:
- MUL 7 × −3 (64-bit): start → done at k+66, result=0xFFFF_FFFF_FFFF_FFEB.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 2 → result=1; MULH of the same operands → result=0xFFFF_FFFF_FFFF_FFFF.
- DIV −7 / 2 → −3; REM −7 / 2 → −1; DIVUW 0x8000_0000 / 1 → 0xFFFF_FFFF_8000_0000, done at k+34.
- DIVU 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF at k+2; REM 5 / 0 → 5; DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000; REMW of the 32-bit overflow case → 0.
- RST pulsed at cycle k+10 of a DIV → busy=0 next cycle, no done pulse; a new start after reset completes correctly.
- start held high with operands changing during CALC → only the first operands are used; the result is stable after done until the next accepted start.
